// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with a two-stage pixel fetch pipeline
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] pix_rgb,
    output logic        rd_en,
    output logic [11:0] rd_x,
    output logic [11:0] rd_y,
    output logic        h_sync,
    output logic        v_sync,
    output logic        dvi_de,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        busy
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST  = 12'(HT - 1);
    localparam logic [11:0] V_LAST  = 12'(VT - 1);
    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;

    logic        running, h_wrap, frame_end, active, hs_raw, vs_raw;

    logic        a_de_q, a_de_d, a_hs_q, a_hs_d, a_vs_q, a_vs_d, a_first_q, a_first_d;
    logic [11:0] a_x_q, a_x_d, a_y_q, a_y_d;
    logic        b_de_q, b_de_d, b_hs_q, b_hs_d, b_vs_q, b_vs_d, b_first_q, b_first_d;
    logic        o_de_q, o_de_d, o_hs_q, o_hs_d, o_vs_q, o_vs_d, o_first_q, o_first_d;
    logic [23:0] o_rgb_q, o_rgb_d;

    always_comb begin
        running   = (state_q != ST_IDLE);
        h_wrap    = (h_cnt_q == H_LAST);
        frame_end = h_wrap && (v_cnt_q == V_LAST);

        // A frame only ends at its last pixel; en merely decides whether another follows.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = frame_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (en)             state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);

        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
        if (running) begin
            h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
            v_cnt_d = v_cnt_q;
            if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end

        active = running && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_raw = running && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_raw = running && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

        a_de_d    = active;
        a_hs_d    = hs_raw;
        a_vs_d    = vs_raw;
        a_first_d = active && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        a_x_d     = active ? h_cnt_q : 12'd0;
        a_y_d     = active ? v_cnt_q : 12'd0;

        b_de_d    = a_de_q;
        b_hs_d    = a_hs_q;
        b_vs_d    = a_vs_q;
        b_first_d = a_first_q;

        // pix_rgb answers the request issued one cycle earlier, i.e. the one now in stage B.
        o_de_d    = b_de_q;
        o_hs_d    = b_hs_q ? SYNC_POL : ~SYNC_POL;
        o_vs_d    = b_vs_q ? SYNC_POL : ~SYNC_POL;
        o_first_d = b_first_q;
        o_rgb_d   = b_de_q ? pix_rgb : 24'd0;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            h_cnt_q   <= 12'd0;
            v_cnt_q   <= 12'd0;
            a_de_q    <= 1'b0;
            a_hs_q    <= 1'b0;
            a_vs_q    <= 1'b0;
            a_first_q <= 1'b0;
            a_x_q     <= 12'd0;
            a_y_q     <= 12'd0;
            b_de_q    <= 1'b0;
            b_hs_q    <= 1'b0;
            b_vs_q    <= 1'b0;
            b_first_q <= 1'b0;
            o_de_q    <= 1'b0;
            o_hs_q    <= ~SYNC_POL;
            o_vs_q    <= ~SYNC_POL;
            o_first_q <= 1'b0;
            o_rgb_q   <= 24'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            a_de_q    <= a_de_d;
            a_hs_q    <= a_hs_d;
            a_vs_q    <= a_vs_d;
            a_first_q <= a_first_d;
            a_x_q     <= a_x_d;
            a_y_q     <= a_y_d;
            b_de_q    <= b_de_d;
            b_hs_q    <= b_hs_d;
            b_vs_q    <= b_vs_d;
            b_first_q <= b_first_d;
            o_de_q    <= o_de_d;
            o_hs_q    <= o_hs_d;
            o_vs_q    <= o_vs_d;
            o_first_q <= o_first_d;
            o_rgb_q   <= o_rgb_d;
        end
    end

    assign rd_en       = a_de_q;
    assign rd_x        = a_x_q;
    assign rd_y        = a_y_q;
    assign dvi_de      = o_de_q;
    assign h_sync      = o_hs_q;
    assign v_sync      = o_vs_q;
    assign frame_start = o_first_q;
    assign red         = o_rgb_q[23:16];
    assign green       = o_rgb_q[15:8];
    assign blue        = o_rgb_q[7:0];
    assign busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - bench for video_timing_gen against a frame-position reference model
module tb_video_timing_gen;
    localparam int N = 3;
    // instance 0: default timing, 1: medium raster, 2: tiny raster with positive syncs
    localparam int HA [N] = '{640, 40, 4};
    localparam int HF [N] = '{16, 4, 1};
    localparam int HS [N] = '{96, 8, 2};
    localparam int HB [N] = '{48, 4, 1};
    localparam int VA [N] = '{480, 30, 2};
    localparam int VF [N] = '{10, 3, 1};
    localparam int VS [N] = '{2, 2, 1};
    localparam int VB [N] = '{33, 5, 1};
    localparam int SP [N] = '{0, 0, 1};

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        first;
        logic [11:0] x;
        logic [11:0] y;
    } dec_t;

    logic        clk;
    logic        rst_n [N];
    logic        en [N];
    logic [23:0] pix [N];
    logic        rd_en [N];
    logic [11:0] rd_x [N];
    logic [11:0] rd_y [N];
    logic        h_sync [N];
    logic        v_sync [N];
    logic        dvi_de [N];
    logic [7:0]  red [N];
    logic [7:0]  green [N];
    logic [7:0]  blue [N];
    logic        frame_start [N];
    logic        busy [N];

    int n_assert;
    int n_fail;

    bit m_busy [N];
    int m_pos [N];
    bit h_busy [N][3];
    int h_pos [N][3];

    int tk;
    int c_de [N];
    int c_fs [N];
    int c_hs [N];
    int c_vs [N];
    int c_busy [N];
    int first_hs [N];
    int first_rd [N];
    int first_de [N];
    int fs_at_de [N];
    int rst_hold [N];
    int guard;

    video_timing_gen u_dflt (
        .clk_pix(clk), .rst_n(rst_n[0]), .en(en[0]), .pix_rgb(pix[0]),
        .rd_en(rd_en[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]),
        .h_sync(h_sync[0]), .v_sync(v_sync[0]), .dvi_de(dvi_de[0]),
        .red(red[0]), .green(green[0]), .blue(blue[0]),
        .frame_start(frame_start[0]), .busy(busy[0])
    );

    video_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5), .SYNC_POL(1'b0)
    ) u_med (
        .clk_pix(clk), .rst_n(rst_n[1]), .en(en[1]), .pix_rgb(pix[1]),
        .rd_en(rd_en[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]),
        .h_sync(h_sync[1]), .v_sync(v_sync[1]), .dvi_de(dvi_de[1]),
        .red(red[1]), .green(green[1]), .blue(blue[1]),
        .frame_start(frame_start[1]), .busy(busy[1])
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_tiny (
        .clk_pix(clk), .rst_n(rst_n[2]), .en(en[2]), .pix_rgb(pix[2]),
        .rd_en(rd_en[2]), .rd_x(rd_x[2]), .rd_y(rd_y[2]),
        .h_sync(h_sync[2]), .v_sync(v_sync[2]), .dvi_de(dvi_de[2]),
        .red(red[2]), .green(green[2]), .blue(blue[2]),
        .frame_start(frame_start[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel source: answers every read one cycle later with {x, y, A5}.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) pix[i] <= {rd_x[i][7:0], rd_y[i][7:0], 8'hA5};
    end

    function automatic int ht(int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vt(int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    function automatic dec_t decode(int i, bit b, int pos);
        dec_t d;
        int h;
        int v;
        d = '0;
        h = pos % ht(i);
        v = pos / ht(i);
        if (b) begin
            d.de    = (h < HA[i]) && (v < VA[i]);
            d.hs    = (h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]);
            d.vs    = (v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]);
            d.first = d.de && (pos == 0);
            if (d.de) begin
                d.x = 12'(h);
                d.y = 12'(v);
            end
        end
        return d;
    endfunction

    task automatic model_reset(int i);
        m_busy[i] = 1'b0;
        m_pos[i]  = 0;
        for (int k = 0; k < 3; k++) begin
            h_busy[i][k] = 1'b0;
            h_pos[i][k]  = 0;
        end
    endtask

    // Running state advances one raster position per cycle; stopping happens only at frame end.
    task automatic model_step(int i, bit en_s);
        h_busy[i][2] = h_busy[i][1];
        h_pos[i][2]  = h_pos[i][1];
        h_busy[i][1] = h_busy[i][0];
        h_pos[i][1]  = h_pos[i][0];
        h_busy[i][0] = m_busy[i];
        h_pos[i][0]  = m_pos[i];
        if (!m_busy[i] || m_pos[i] == ht(i) * vt(i) - 1) begin
            m_busy[i] = en_s;
            m_pos[i]  = 0;
        end else begin
            m_pos[i] = m_pos[i] + 1;
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        dec_t r;
        dec_t o;
        bit sp;
        logic [53:0] exp_v;
        logic [53:0] obs_v;
        for (int i = 0; i < N; i++) begin
            sp = (SP[i] != 0);
            r = decode(i, h_busy[i][0], h_pos[i][0]);
            o = decode(i, h_busy[i][2], h_pos[i][2]);
            exp_v = {m_busy[i], r.de, r.x, r.y, o.de, o.hs ? sp : ~sp, o.vs ? sp : ~sp, o.first,
                     o.de ? {o.x[7:0], o.y[7:0], 8'hA5} : 24'h0};
            obs_v = {busy[i], rd_en[i], rd_x[i], rd_y[i], dvi_de[i], h_sync[i], v_sync[i],
                     frame_start[i], red[i], green[i], blue[i]};
            n_assert++;
            assert (obs_v === exp_v)
            else begin
                n_fail++;
                $error("FAIL %s inst%0d t=%0t: observed %h expected %h", tag, i, $time, obs_v, exp_v);
            end
        end
    endtask

    task automatic clear_counts();
        tk = 0;
        for (int i = 0; i < N; i++) begin
            c_de[i] = 0; c_fs[i] = 0; c_hs[i] = 0; c_vs[i] = 0; c_busy[i] = 0;
            first_hs[i] = -1; first_rd[i] = -1; first_de[i] = -1; fs_at_de[i] = -1;
        end
    endtask

    task automatic tick();
        bit en_s [N];
        bit rst_s [N];
        bit sp;
        for (int i = 0; i < N; i++) begin
            en_s[i]  = en[i];
            rst_s[i] = rst_n[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst_s[i]) model_reset(i);
            else           model_step(i, en_s[i]);
        end
        check_all("cycle");
        if (h_busy[1][2] && h_pos[1][2] == 7 * ht(1) + 5)
            chk("rgb_at_5_7", 64'({red[1], green[1], blue[1]}), 64'h0507A5);
        tk++;
        for (int i = 0; i < N; i++) begin
            sp = (SP[i] != 0);
            if (dvi_de[i]) c_de[i]++;
            if (frame_start[i]) c_fs[i]++;
            if (busy[i]) c_busy[i]++;
            if (v_sync[i] == sp) c_vs[i]++;
            if (h_sync[i] == sp) begin
                c_hs[i]++;
                if (first_hs[i] < 0) first_hs[i] = tk;
            end
            if (rd_en[i] && first_rd[i] < 0) first_rd[i] = tk;
            if (dvi_de[i] && first_de[i] < 0) begin
                first_de[i] = tk;
                fs_at_de[i] = int'(frame_start[i]);
            end
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0;
            en[i]    = 1'b0;
            rst_hold[i] = 0;
            model_reset(i);
        end
        clear_counts();
        repeat (3) tick();
        for (int i = 0; i < N; i++)
            chk("reset_values", 64'({busy[i], rd_en[i], dvi_de[i], frame_start[i], h_sync[i], v_sync[i],
                red[i], green[i], blue[i]}), {34'd0, 4'b0000, {2{~SP[i][0]}}, 24'd0});
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        tick();

        // default raster line timing and tiny raster, run side by side
        en[0] = 1'b1;
        en[2] = 1'b1;
        clear_counts();
        repeat (1603) tick();
        chk("dflt_de_two_lines", 64'(c_de[0]), 64'd1280);
        chk("dflt_hsync_cycles", 64'(c_hs[0]), 64'd192);
        chk("dflt_hsync_start", 64'(first_hs[0]), 64'd660);
        chk("dflt_vsync_none", 64'(c_vs[0]), 64'd0);
        chk("dflt_frame_start", 64'(c_fs[0]), 64'd1);
        chk("tiny_de_40_frames", 64'(c_de[2]), 64'd320);
        chk("tiny_hsync_cycles", 64'(c_hs[2]), 64'd400);
        chk("tiny_hsync_start", 64'(first_hs[2]), 64'd9);
        chk("tiny_vsync_cycles", 64'(c_vs[2]), 64'd320);
        chk("tiny_frame_start", 64'(c_fs[2]), 64'd40);
        en[0] = 1'b0;
        en[2] = 1'b0;

        // medium raster: two full frames
        en[1] = 1'b1;
        clear_counts();
        repeat (4483) tick();
        chk("med_de_two_frames", 64'(c_de[1]), 64'd2400);
        chk("med_frame_start", 64'(c_fs[1]), 64'd2);
        chk("med_hsync_cycles", 64'(c_hs[1]), 64'd640);
        chk("med_vsync_cycles", 64'(c_vs[1]), 64'd224);

        // en dropped on line 10 of the third frame
        clear_counts();
        for (int j = 0; j < 2250; j++) begin
            if (en[1] && m_pos[1] == 10 * ht(1)) en[1] = 1'b0;
            tick();
        end
        chk("drop_taken", 64'(en[1]), 64'd0);
        chk("drop_busy_to_end", 64'(c_busy[1]), 64'd2237);
        chk("drop_full_frame_de", 64'(c_de[1]), 64'd1200);
        chk("drop_frame_start", 64'(c_fs[1]), 64'd1);
        chk("drop_idle_outputs", 64'({busy[1], rd_en[1], dvi_de[1], h_sync[1], v_sync[1], red[1], green[1], blue[1]}),
            64'({5'b00011, 24'd0}));

        // en dropped and re-raised inside each of two frames
        en[1] = 1'b1;
        clear_counts();
        for (int j = 1; j <= 4483; j++) begin
            en[1] = !((j > 300 && j < 900) || (j > 4240 && j < 4340));
            tick();
        end
        chk("toggle_de", 64'(c_de[1]), 64'd2400);
        chk("toggle_frame_start", 64'(c_fs[1]), 64'd2);
        chk("toggle_busy", 64'(c_busy[1]), 64'd4483);
        en[1] = 1'b0;
        guard = 0;
        while (busy[1] && guard < 2400) begin
            tick();
            guard++;
        end
        chk("toggle_reaches_idle", 64'(busy[1]), 64'd0);

        // reset mid-frame at line 20, pixel 30
        en[1] = 1'b1;
        guard = 0;
        while (!(m_busy[1] && m_pos[1] == 20 * ht(1) + 30) && guard < 3000) begin
            tick();
            guard++;
        end
        chk("reset_point_reached", 64'(m_pos[1]), 64'(20 * ht(1) + 30));
        rst_n[1] = 1'b0;
        #1;
        model_reset(1);
        check_all("reset_async");
        chk("reset_async_values", 64'({busy[1], rd_en[1], dvi_de[1], frame_start[1], h_sync[1], v_sync[1],
            red[1], green[1], blue[1]}), 64'({6'b000011, 24'd0}));
        repeat (3) tick();
        rst_n[1] = 1'b1;
        clear_counts();
        repeat (8) tick();
        chk("restart_first_rd", 64'(first_rd[1]), 64'd2);
        chk("restart_first_de", 64'(first_de[1]), 64'd4);
        chk("restart_frame_start", 64'(fs_at_de[1]), 64'd1);

        // random en toggling and reset pulses on the small rasters
        for (int j = 0; j < 12000; j++) begin
            for (int i = 1; i < N; i++) begin
                if (rst_hold[i] > 0) begin
                    rst_hold[i]--;
                    if (rst_hold[i] == 0) rst_n[i] = 1'b1;
                end else if ($urandom_range(2999, 0) == 0) begin
                    rst_n[i] = 1'b0;
                    rst_hold[i] = int'($urandom_range(3, 1));
                end
                if ($urandom_range(150, 0) == 0) en[i] = ~en[i];
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
